// File: rtl/mvau_deadlock_report_ctrl_if.sv
// Report stream carrying one confirmed-deadlock record (monitor index + capture timestamp).
// The controller drives it through the master modport and the logger consumes it through slave.
interface mvau_deadlock_report_ctrl_if #(
  parameter int IDX_W = 2,
  parameter int TS_W  = 32
);
  logic             report_valid;
  logic             report_ready;
  logic [IDX_W-1:0] report_idx;
  logic [TS_W-1:0]  report_ts;

  modport master (output report_valid, report_idx, report_ts, input report_ready);
  modport slave  (input report_valid, report_idx, report_ts, output report_ready);
endinterface

// File: rtl/mvau_deadlock_report_ctrl.sv
// Filters per-kernel deadlock block flags with a persistence threshold, latches confirmed
// deadlocks sticky, and reports each one once over a round-robin arbitrated valid/ready stream.
module mvau_deadlock_report_ctrl #(
  parameter int N_MON  = 4,
  parameter int THRESH = 8,
  parameter int TS_W   = 32,
  localparam int IDX_W = (N_MON > 1) ? $clog2(N_MON) : 1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic                        clear,
  input  logic [N_MON-1:0]            mon_block,
  mvau_deadlock_report_ctrl_if.master rpt,
  output logic                        deadlock,
  output logic [N_MON-1:0]            confirmed
);

  localparam int          CNT_W = $clog2(THRESH);
  localparam int unsigned NM    = N_MON;

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state, state_next;
  logic [TS_W-1:0]  ts;
  logic [TS_W-1:0]  ts_cap [N_MON];
  logic [CNT_W-1:0] cnt    [N_MON];
  logic [N_MON-1:0] reported;
  logic [N_MON-1:0] pending;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] report_idx;
  logic [TS_W-1:0]  report_ts;
  logic             sel_found;
  logic             load;
  logic             handshake;
  int unsigned      pos;

  assign pending          = confirmed & ~reported;
  assign deadlock         = |confirmed;
  assign rpt.report_valid = (state == SEND);
  assign rpt.report_idx   = report_idx;
  assign rpt.report_ts    = report_ts;

  // Cyclic first-set search starting at rr_ptr.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    pos       = 0;
    for (int unsigned k = 0; k < NM; k++) begin
      pos = 32'(rr_ptr) + k;
      if (pos >= NM) pos = pos - NM;
      if (!sel_found && pending[pos]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(pos);
      end
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    handshake  = 1'b0;
    case (state)
      IDLE: if (sel_found) begin
        load       = 1'b1;
        state_next = SEND;
      end
      SEND: if (rpt.report_ready) begin
        handshake  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)   state <= IDLE;
    else if (clear) state <= IDLE;
    else            state <= state_next;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ts         <= '0;
      confirmed  <= '0;
      reported   <= '0;
      rr_ptr     <= '0;
      report_idx <= '0;
      report_ts  <= '0;
      for (int unsigned i = 0; i < NM; i++) begin
        cnt[i]    <= '0;
        ts_cap[i] <= '0;
      end
    end else if (clear) begin
      ts         <= '0;
      confirmed  <= '0;
      reported   <= '0;
      rr_ptr     <= '0;
      report_idx <= '0;
      report_ts  <= '0;
      for (int unsigned i = 0; i < NM; i++) begin
        cnt[i]    <= '0;
        ts_cap[i] <= '0;
      end
    end else begin
      if (enable && ts != '1) ts <= ts + TS_W'(1);
      // Counter parks at THRESH-1 once confirmed; ts_cap takes the pre-increment timestamp.
      for (int unsigned i = 0; i < NM; i++) begin
        if (!enable || !mon_block[i]) begin
          cnt[i] <= '0;
        end else if (!confirmed[i]) begin
          if (cnt[i] == CNT_W'(THRESH - 1)) begin
            confirmed[i] <= 1'b1;
            ts_cap[i]    <= ts;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end
      end
      if (load) begin
        report_idx <= sel_idx;
        report_ts  <= ts_cap[sel_idx];
      end
      if (handshake) begin
        reported[report_idx] <= 1'b1;
        rr_ptr <= (report_idx == IDX_W'(N_MON - 1)) ? '0 : report_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mvau_deadlock_report_ctrl.sv
// Directed, table-driven bench for mvau_deadlock_report_ctrl with N_MON=4, THRESH=8, TS_W=32.
// Each record gives inputs for one or more edges and the outputs expected just after each edge.
module tb_mvau_deadlock_report_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       clear;
  logic [3:0] mon_block;
  logic       deadlock;
  logic [3:0] confirmed;

  mvau_deadlock_report_ctrl_if #(.IDX_W(2), .TS_W(32)) rif ();

  mvau_deadlock_report_ctrl #(.N_MON(4), .THRESH(8), .TS_W(32)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .clear     (clear),
    .mon_block (mon_block),
    .rpt       (rif),
    .deadlock  (deadlock),
    .confirmed (confirmed)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        en;
    logic        clr;
    logic        rdy;
    logic [3:0]  blk;
    int          n;
    logic        ev;
    logic [1:0]  eidx;
    logic [31:0] ets;
    logic [3:0]  econf;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   hs_cnt   = 0;

  task automatic add(input logic en, input logic clr, input logic rdy, input logic [3:0] blk,
                     input int n, input logic ev, input logic [1:0] eidx,
                     input logic [31:0] ets, input logic [3:0] econf);
    vec_t v;
    v.en = en; v.clr = clr; v.rdy = rdy; v.blk = blk; v.n = n;
    v.ev = ev; v.eidx = eidx; v.ets = ets; v.econf = econf;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      for (int r = 0; r < vecs[i].n; r++) begin
        enable           = vecs[i].en;
        clear            = vecs[i].clr;
        rif.report_ready = vecs[i].rdy;
        mon_block        = vecs[i].blk;
        if (rif.report_valid && vecs[i].rdy && !vecs[i].clr) hs_cnt++;
        @(posedge clock);
        #1;
        check($sformatf("v%0d.%0d confirmed", i, r), 64'(confirmed), 64'(vecs[i].econf));
        check($sformatf("v%0d.%0d deadlock", i, r), 64'(deadlock), 64'(|vecs[i].econf));
        check($sformatf("v%0d.%0d valid", i, r), 64'(rif.report_valid), 64'(vecs[i].ev));
        if (vecs[i].ev) begin
          check($sformatf("v%0d.%0d idx", i, r), 64'(rif.report_idx), 64'(vecs[i].eidx));
          check($sformatf("v%0d.%0d ts", i, r), 64'(rif.report_ts), 64'(vecs[i].ets));
        end
      end
    end
  endtask

  initial begin
    int rr_lo, rr_hi, hs_before;

    // Single deadlock on monitor 2 from edge 10, consumer always ready.
    add(1, 0, 1, 4'b0000, 10, 0, 0, 0,  4'b0000);
    add(1, 0, 1, 4'b0100,  7, 0, 0, 0,  4'b0000);
    add(1, 0, 1, 4'b0100,  1, 0, 0, 0,  4'b0100);
    add(1, 0, 1, 4'b0100,  1, 1, 2, 17, 4'b0100);
    add(1, 0, 1, 4'b0100,  3, 0, 0, 0,  4'b0100);
    // Transient stalls never confirm.
    add(1, 1, 1, 4'b0000,  1, 0, 0, 0,  4'b0000);
    add(1, 0, 1, 4'b0010,  7, 0, 0, 0,  4'b0000);
    add(1, 0, 1, 4'b0000,  1, 0, 0, 0,  4'b0000);
    add(1, 0, 1, 4'b0010,  7, 0, 0, 0,  4'b0000);
    add(1, 0, 1, 4'b0000,  2, 0, 0, 0,  4'b0000);
    // Simultaneous confirm of 0,1,3 with toggling ready.
    add(1, 1, 0, 4'b0000,  1, 0, 0, 0,  4'b0000);
    rr_lo = vecs.size();
    add(1, 0, 0, 4'b1011,  7, 0, 0, 0,  4'b0000);
    add(1, 0, 0, 4'b1011,  1, 0, 0, 0,  4'b1011);
    add(1, 0, 0, 4'b1011,  2, 1, 0, 7,  4'b1011);
    add(1, 0, 1, 4'b1011,  1, 0, 0, 0,  4'b1011);
    add(1, 0, 0, 4'b1011,  1, 1, 1, 7,  4'b1011);
    add(1, 0, 1, 4'b1011,  1, 0, 0, 0,  4'b1011);
    add(1, 0, 0, 4'b1011,  1, 1, 3, 7,  4'b1011);
    add(1, 0, 1, 4'b1011,  1, 0, 0, 0,  4'b1011);
    add(1, 0, 0, 4'b1011,  1, 0, 0, 0,  4'b1011);
    add(1, 0, 1, 4'b1011,  1, 0, 0, 0,  4'b1011);
    rr_hi = vecs.size();
    // Backpressure for 20 cycles, then clear together with ready; ts restarts.
    add(1, 1, 0, 4'b0000,  1, 0, 0, 0,  4'b0000);
    add(1, 0, 0, 4'b0001,  7, 0, 0, 0,  4'b0000);
    add(1, 0, 0, 4'b0001,  1, 0, 0, 0,  4'b0001);
    add(1, 0, 0, 4'b0001, 20, 1, 0, 7,  4'b0001);
    add(1, 1, 1, 4'b0001,  1, 0, 0, 0,  4'b0000);
    add(1, 0, 1, 4'b0001,  7, 0, 0, 0,  4'b0000);
    add(1, 0, 1, 4'b0001,  1, 0, 0, 0,  4'b0001);
    add(1, 0, 1, 4'b0001,  1, 1, 0, 7,  4'b0001);
    add(1, 0, 1, 4'b0000,  2, 0, 0, 0,  4'b0001);
    // Enable low freezes ts and counters; then all four confirm and rotate.
    add(1, 1, 1, 4'b0000,  1, 0, 0, 0,  4'b0000);
    add(0, 0, 1, 4'b1111, 50, 0, 0, 0,  4'b0000);
    add(1, 0, 1, 4'b1111,  7, 0, 0, 0,  4'b0000);
    add(1, 0, 1, 4'b1111,  1, 0, 0, 0,  4'b1111);
    add(1, 0, 1, 4'b1111,  1, 1, 0, 7,  4'b1111);
    add(1, 0, 1, 4'b1111,  1, 0, 0, 0,  4'b1111);
    add(1, 0, 1, 4'b1111,  1, 1, 1, 7,  4'b1111);
    add(1, 0, 1, 4'b1111,  1, 0, 0, 0,  4'b1111);
    add(1, 0, 1, 4'b1111,  1, 1, 2, 7,  4'b1111);
    add(1, 0, 1, 4'b1111,  1, 0, 0, 0,  4'b1111);
    add(1, 0, 1, 4'b1111,  1, 1, 3, 7,  4'b1111);
    add(1, 0, 1, 4'b1111,  2, 0, 0, 0,  4'b1111);
    // Set up a pending report ahead of the asynchronous reset.
    add(1, 1, 0, 4'b0000,  1, 0, 0, 0,  4'b0000);
    add(1, 0, 0, 4'b0100,  7, 0, 0, 0,  4'b0000);
    add(1, 0, 0, 4'b0100,  1, 0, 0, 0,  4'b0100);
    add(1, 0, 0, 4'b0100,  1, 1, 2, 7,  4'b0100);

    reset_n          = 1'b0;
    enable           = 1'b0;
    clear            = 1'b0;
    mon_block        = '0;
    rif.report_ready = 1'b0;
    #12;
    check("reset valid", 64'(rif.report_valid), 64'd0);
    check("reset idx", 64'(rif.report_idx), 64'd0);
    check("reset ts", 64'(rif.report_ts), 64'd0);
    check("reset deadlock", 64'(deadlock), 64'd0);
    check("reset confirmed", 64'(confirmed), 64'd0);
    reset_n = 1'b1;

    run(0, rr_lo);
    hs_before = hs_cnt;
    run(rr_lo, rr_hi);
    check("rr handshakes", 64'(hs_cnt - hs_before), 64'd3);
    run(rr_hi, vecs.size());
    check("total handshakes", 64'(hs_cnt), 64'd9);

    // Asynchronous reset while SEND is holding a report; no clock edge in between.
    check("pre-reset valid", 64'(rif.report_valid), 64'd1);
    #3;
    reset_n = 1'b0;
    #1;
    check("async valid", 64'(rif.report_valid), 64'd0);
    check("async idx", 64'(rif.report_idx), 64'd0);
    check("async ts", 64'(rif.report_ts), 64'd0);
    check("async deadlock", 64'(deadlock), 64'd0);
    check("async confirmed", 64'(confirmed), 64'd0);
    #2;
    reset_n          = 1'b1;
    mon_block        = '0;
    rif.report_ready = 1'b0;
    @(posedge clock);
    #1;
    check("post-reset valid", 64'(rif.report_valid), 64'd0);
    check("post-reset confirmed", 64'(confirmed), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mvau_deadlock_report_ctrl.md
# mvau_deadlock_report_ctrl

Collects the per-kernel deadlock `block` flags produced by the MVAU stage deadlock monitors and filters out transient stalls with a persistence threshold. Confirmed deadlocks are latched sticky. Each confirmed monitor is reported exactly once over a valid/ready stream, with a capture timestamp, arbitrated round-robin. The block sits at the top of the simulation/debug wrapper, between the monitor instances and the testbench or host-side deadlock logger.

## Interface
- `N_MON`, 4: number of monitored kernels (1..16).
- `THRESH`, 8: consecutive blocked cycles required to confirm a deadlock (≥2).
- `TS_W`, 32: width of the free-running cycle timestamp.
- `IDX_W`, derived as clog2(N_MON), minimum 1: report index width.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  monitoring enable; when low, persistence counters are held at 0 and the timestamp is frozen.
- `clear`  in  1  synchronous clear of all detection and report state.
- `mon_block`  in  N_MON  level `block` outputs of the per-kernel deadlock monitors.
- `report_valid`  out  1  report word available.
- `report_ready`  in  1  consumer accepts the report.
- `report_idx`  out  IDX_W  index of the reported monitor.
- `report_ts`  out  TS_W  timestamp captured when that monitor was confirmed.
- `deadlock`  out  1  sticky OR of all confirmed bits.
- `confirmed`  out  N_MON  sticky per-monitor confirmed mask.

## Operation
- Timestamp `ts`:
  - Increments every cycle while `enable` is high.
  - Saturates at 2^TS_W−1; it never wraps.
- Persistence counter per monitor, `cnt[i]`, width clog2(THRESH):
  - Increments on each edge where `enable & mon_block[i] & ~confirmed[i]`.
  - Resets to 0 on any edge where `mon_block[i]` is low or `enable` is low.
- Confirmation:
  - On an edge where `cnt[i] == THRESH−1` and the increment condition holds, `confirmed[i]` is set.
  - In the same edge, `ts_cap[i]` captures the current `ts`, i.e. the pre-increment value.
  - `cnt[i]` then holds.
  - `confirmed[i]` stays set until `clear` or reset, even if `mon_block[i]` drops.
- `pending` = `confirmed & ~reported`.
- Report FSM, two states:
  - IDLE: if `pending` is non-zero, select the first set bit at or after `rr_ptr`, searching cyclically. Register `report_idx` and `report_ts = ts_cap[idx]`, set `report_valid`, and go to SEND.
  - SEND: hold `report_valid`, `report_idx` and `report_ts` stable until `report_ready`. On the handshake edge:
    - set `reported[idx]`;
    - set `rr_ptr = (idx+1) mod N_MON`;
    - clear `report_valid`;
    - return to IDLE.
  - Minimum gap between two reports is one cycle, spent in IDLE.
- `clear` has priority over all other updates. On the edge where it is sampled, it zeroes `cnt`, `confirmed`, `reported`, `ts_cap`, `ts` and `rr_ptr`, drops `report_valid`, and forces IDLE. This applies even mid-SEND; that is the one allowed valid withdrawal.
- Simultaneous events:
  - Several monitors confirming on the same edge each capture the same `ts`. They are reported in round-robin order.
  - A monitor confirming while another report is in SEND waits its turn.
  - `clear` and `report_ready` on the same edge: clear wins and the handshake is void.

## Timing
- Reset values, with `reset_n` low, asynchronously: `report_valid` 0, `report_idx` 0, `report_ts` 0, `deadlock` 0, `confirmed` 0; also `ts` 0, all `cnt` 0, `rr_ptr` 0, FSM in IDLE.
- Confirmation latency: if `mon_block[i]` is first sampled high at edge E and stays high, `confirmed[i]` and `deadlock` are high after edge E+THRESH−1.
- Report latency: `report_valid` rises one edge after the confirm edge, provided the FSM is in IDLE.
- Release of `reset_n` is synchronised externally. The first active edge after release counts as cycle 0 of `ts`.

## Test plan
- Single deadlock:
  - Stimulus: THRESH=8, `mon_block[2]` high from edge 10 and held, `report_ready`=1.
  - Required: `confirmed`=4'b0100 after edge 17, `report_valid` for one cycle after edge 18, `report_idx`=2, `report_ts`=17.
- Transient filter: `mon_block[1]` high for 7 cycles, low for 1, high for 7 -> `confirmed` stays 0 and `report_valid` never rises.
- Simultaneous confirm plus round-robin:
  - Stimulus: `mon_block[0]`, `[1]` and `[3]` rise on the same edge; `report_ready` toggles 0,1.
  - Required: reports in idx order 0,1,3, all with equal `report_ts`. Each report's fields are stable while `report_ready`=0. Exactly three handshakes, and `deadlock` stays 1.
- Backpressure then clear: confirm monitor 0, hold `report_ready`=0 for 20 cycles, then pulse `clear` -> `report_valid`, `confirmed` and `deadlock` are 0 after the clear edge; `ts` restarts from 0.
- Enable gating: `enable`=0 with all `mon_block` high for 50 cycles -> no confirmation and `ts` unchanged. After `enable` rises, confirmation occurs at exactly THRESH edges.
- Async reset mid-SEND: assert `reset_n`=0 between clock edges while `report_valid`=1 -> all outputs drop to 0 immediately, without waiting for a clock edge.
